// File: rtl/saturate_clamp_pkg.sv
// Shared width defaults and the clamp function for saturate_clamp.
// Used by the top; the optional statistics build is selected with SATURATE_STATS_EN.
package sat_pkg;

    localparam int IN_W_DEF  = 10;
    localparam int OUT_W_DEF = 8;
    localparam int CNT_W_DEF = 16;

    typedef struct packed {
        logic [15:0] data;
        logic        ovf;
        logic        udf;
    } clamp_t;

    // Operates on a sign-extended 32-bit view so any IN_W <= 32 / OUT_W <= 16 pair can share it.
    function automatic clamp_t sat_clamp(input logic signed [31:0] v, input int unsigned out_w);
        clamp_t r;
        int     max_v;
        r     = '0;
        max_v = (1 << out_w) - 1;
        if (v < 0) begin
            r.udf = 1'b1;
        end else if (v > max_v) begin
            r.ovf  = 1'b1;
            r.data = 16'(max_v);
        end else begin
            r.data = v[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/saturate_clamp_if.sv
// Sample bus for saturate_clamp: input sample plus combinational and registered results.
interface saturate_clamp_if #(
    parameter int IN_W  = 10,
    parameter int OUT_W = 8
);
    logic                    in_valid;
    logic signed [IN_W-1:0]  in_data;
    logic [OUT_W-1:0]        sat_comb;
    logic                    out_valid;
    logic [OUT_W-1:0]        out_data;
    logic                    out_ovf;
    logic                    out_udf;

    modport master (
        output in_valid, in_data,
        input  sat_comb, out_valid, out_data, out_ovf, out_udf
    );

    modport slave (
        input  in_valid, in_data,
        output sat_comb, out_valid, out_data, out_ovf, out_udf
    );
endinterface

// File: rtl/saturate_clamp_counter.sv
// Saturating up-counter with synchronous clear; clear beats a same-cycle increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/saturate_clamp.sv
// Clamp a signed sample to [0, 2^OUT_W-1], combinationally and through a 1-cycle valid pipe.
// Define SATURATE_STATS_EN to add saturating overflow/underflow event counters.
module saturate_clamp
    import sat_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    saturate_clamp_if.slave   bus
`ifdef SATURATE_STATS_EN
    ,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  ovf_cnt,
    output logic [CNT_W-1:0]  udf_cnt
`endif
);
    clamp_t           cl;
    logic [15:0]      unused_data;
    logic             valid_q, ovf_q, udf_q;
    logic             ovf_d, udf_d;
    logic [OUT_W-1:0] data_q, data_d;

    assign cl          = sat_clamp(32'(bus.in_data), OUT_W);
    assign unused_data = cl.data;
    assign bus.sat_comb = cl.data[OUT_W-1:0];

    // Flags are per-sample pulses; data holds across idle cycles.
    always_comb begin
        data_d = data_q;
        ovf_d  = 1'b0;
        udf_d  = 1'b0;
        if (bus.in_valid) begin
            data_d = cl.data[OUT_W-1:0];
            ovf_d  = cl.ovf;
            udf_d  = cl.udf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_udf   = udf_q;

`ifdef SATURATE_STATS_EN
    sat_counter #(.CNT_W(CNT_W)) u_ovf_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_stats),
        .inc (bus.in_valid && cl.ovf),
        .cnt (ovf_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_udf_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_stats),
        .inc (bus.in_valid && cl.udf),
        .cnt (udf_cnt)
    );
`endif
endmodule

// File: tb/tb_saturate_clamp.sv
// Directed and random checks of saturate_clamp against an integer reference model.
module tb_saturate_clamp;
    localparam int IN_W  = 10;
    localparam int OUT_W = 8;
`ifdef SATURATE_STATS_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif
    localparam int MAXV  = (1 << OUT_W) - 1;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Reference state
    int   m_data = 0;
    int   m_ocnt = 0;
    int   m_ucnt = 0;

    saturate_clamp_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

`ifdef SATURATE_STATS_EN
    logic             clr_stats = 1'b0;
    logic [CNT_W-1:0] ovf_cnt, udf_cnt;
`endif

    saturate_clamp #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef SATURATE_STATS_EN
        ,
        .clr_stats (clr_stats),
        .ovf_cnt   (ovf_cnt),
        .udf_cnt   (udf_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock step: d is the signed integer sample, r asserts reset, c asserts counter clear.
    task automatic step(input bit v, input int d, input bit r, input bit c);
        int  exp_c;
        bit  o, u;
        bus.in_valid = v;
        bus.in_data  = IN_W'(d);
        rst          = r;
`ifdef SATURATE_STATS_EN
        clr_stats    = c;
`endif
        u     = (d < 0);
        o     = (d > MAXV);
        exp_c = u ? 0 : (o ? MAXV : d);
        #1;
        check("sat_comb", 32'(bus.sat_comb), 32'(exp_c));
        @(posedge clk);
        #1;
        if (r) begin
            m_data = 0;
            check("rst_valid", 32'(bus.out_valid), 32'd0);
            check("rst_data",  32'(bus.out_data),  32'd0);
            check("rst_ovf",   32'(bus.out_ovf),   32'd0);
            check("rst_udf",   32'(bus.out_udf),   32'd0);
        end else begin
            if (v) m_data = exp_c;
            check("out_valid", 32'(bus.out_valid), 32'(v));
            check("out_data",  32'(bus.out_data),  32'(m_data));
            check("out_ovf",   32'(bus.out_ovf),   32'(v && o));
            check("out_udf",   32'(bus.out_udf),   32'(v && u));
        end
        if (r || c) begin
            m_ocnt = 0;
            m_ucnt = 0;
        end else if (v) begin
            if (o && m_ocnt < CMAX) m_ocnt++;
            if (u && m_ucnt < CMAX) m_ucnt++;
        end
`ifdef SATURATE_STATS_EN
        check("ovf_cnt", 32'(ovf_cnt), 32'(m_ocnt));
        check("udf_cnt", 32'(udf_cnt), 32'(m_ucnt));
`endif
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        step(0, 0, 1, 0);
        step(1, 5, 1, 0);
        // In-range values pass through
        step(1, 'h000, 0, 0);
        step(1, 'h07F, 0, 0);
        step(1, 'h0FF, 0, 0);
        // Overflow
        step(1, 256, 0, 0);
        step(1, 511, 0, 0);
        // Underflow
        step(1, -1, 0, 0);
        step(1, -512, 0, 0);
        // Hold with idle cycles; ovf pulses once
        step(1, 'h180, 0, 0);
        step(0, 'h010, 0, 0);
        step(0, -7, 0, 0);
        // Reset mid-stream drops the sample, then resumes
        step(1, 'h100, 1, 0);
        step(1, 'h042, 0, 0);
        // Counter saturation and clear-vs-increment priority
        for (int i = 0; i < 5; i++) step(1, 300 + i, 0, 0);
        step(1, 400, 0, 1);
        for (int i = 0; i < 4; i++) step(1, -10 - i, 0, 0);
        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 1023)) - 512,
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 24) == 0));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/saturate_clamp.md
Name: saturate_clamp

Overview:
- Clamps a signed two's-complement value to the unsigned range [0, 2^OUT_W-1].
- Provides a zero-latency combinational result for datapath use, e.g. luminance in the grayscale filter, where a 10-bit value built as {1'b0, LUM[17:9]} is clamped to 8 bits.
- Also provides a registered, valid-qualified result with overflow and underflow flags.
- Sits between pixel arithmetic stages and the 8-bit RGB outputs.

Parameters:
- IN_W, 10, input width in bits; signed two's complement; IN_W > OUT_W required.
- OUT_W, 8, output width in bits; unsigned; 1 <= OUT_W <= 16.
- CNT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample qualifier.
- in_data  in  IN_W  signed input value.
- sat_comb  out  OUT_W  combinational clamp of in_data; ignores in_valid and rst.
- out_valid  out  1  registered in_valid.
- out_data  out  OUT_W  registered clamp result.
- out_ovf  out  1  registered; sample was > 2^OUT_W-1.
- out_udf  out  1  registered; sample was < 0.
- clr_stats  in  1  synchronous counter clear (optional feature only).
- ovf_cnt  out  CNT_W  overflow event count (optional feature only).
- udf_cnt  out  CNT_W  underflow event count (optional feature only).

Behaviour:
- Clamp function:
  - If in_data[IN_W-1]=1 (negative): result 0, udf=1.
  - Else if any of in_data[IN_W-2:OUT_W] is 1: result all-ones (2^OUT_W-1), ovf=1.
  - Else: result in_data[OUT_W-1:0], ovf=udf=0.
  - ovf and udf are mutually exclusive.
- sat_comb: pure combinational clamp; no latency.
- Registered path, 1-cycle latency, on every rising clk:
  - out_valid <= in_valid.
  - When in_valid=1: out_data, out_ovf, out_udf take the clamp result and flags.
  - When in_valid=0: out_data holds its previous value; out_ovf and out_udf go to 0 (flags are per-sample pulses).
- Reset (rst=1 at clk edge): out_valid=0, out_data=0, out_ovf=0, out_udf=0; rst has priority over in_valid.
- Reset mid-stream: the sample presented during the reset cycle is dropped; the next cycle resumes normally.
- No backpressure; a new sample may be accepted every cycle.

Optional Feature:
- Macro: SATURATE_STATS_EN.
- When defined:
  - ovf_cnt increments on each accepted (in_valid=1) overflow sample; udf_cnt likewise for underflow.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - rst or clr_stats clears both counters to 0; clear has priority over a same-cycle increment.
- When not defined: clr_stats, ovf_cnt, udf_cnt ports and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package sat_pkg:
  - Default width constants (IN_W_DEF=10, OUT_W_DEF=8, CNT_W_DEF=16).
  - A pure function sat_clamp(in, returns result and flags) reused by sat_comb and the register path.
- One natural sub-module: sat_counter (saturating up-counter with clear), instantiated twice under SATURATE_STATS_EN.

Test Plan (IN_W=10, OUT_W=8):
- in_data 0x000, 0x07F, 0x0FF with in_valid=1 -> sat_comb and next-cycle out_data 0x00, 0x7F, 0xFF; ovf=udf=0.
- in_data 0x100 (256), 0x1FF (511) -> 0xFF, out_ovf=1, out_udf=0.
- in_data 0x3FF (-1), 0x200 (-512) -> 0x00, out_udf=1, out_ovf=0.
- in_valid=1 with 0x180, then in_valid=0 for two cycles -> out_data holds 0xFF; out_ovf pulses for one cycle; out_valid 1 then 0.
- rst=1 while in_valid=1 and in_data=0x100 -> next cycle out_valid=0, out_data=0x00, flags 0; sat_comb still 0xFF.
- With SATURATE_STATS_EN and CNT_W=2: 5 overflow samples -> ovf_cnt 1,2,3,3,3; clr_stats asserted together with an overflow sample -> ovf_cnt=0.
